// File: rtl/spike_dec_pkg.sv
// Shared definitions for the spike rate decoder: FSM state type,
// default widths and a saturating increment helper.
package spike_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIN_W_D = 8;
  localparam int CNT_W_D = 8;
  localparam int ISI_W_D = 8;

  // Adds one to val when inc is set, but never past max_val.
  // Callers zero-extend their counter to 32 bits and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_edge.sv
// Rising-edge detector for the incoming spike train.
// Build option SPIKE_SYNC_EN inserts a 2-flop synchronizer ahead of the
// detector for spikes arriving from an asynchronous pad (adds 2 cycles of
// spike-to-count latency). Without it spike_in is taken as clk-synchronous.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_lvl;
  logic spk_prev;

`ifdef SPIKE_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer, cleared on reset so no edge appears at release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], spike_in};
    end
  end

  assign spike_lvl = sync_q[1];
`else
  assign spike_lvl = spike_in;
`endif

  // Previous level is tracked every cycle, even while the decoder is
  // disabled, so that resuming never manufactures a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_prev <= 1'b0;
    end else begin
      spk_prev <= spike_lvl;
    end
  end

  assign spike_edge = spike_lvl & ~spk_prev;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: per fixed-length window reports the spike count
// (saturating) and the most recent inter-spike interval through a
// valid/ready output register. A result arriving while the previous one is
// still unaccepted is dropped and flagged on the sticky ovf output.
// Optional build macro: SPIKE_SYNC_EN (input synchronizer, see edge detect).
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int WIN_W = WIN_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ISI_W = ISI_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             ovf
);

  localparam logic [31:0]      CNT_MAX = (32'd1 << CNT_W) - 32'd1;
  localparam logic [31:0]      ISI_MAX = (32'd1 << ISI_W) - 32'd1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t             state;
  state_t             state_next;
  logic               spike_edge;
  logic               win_start;
  logic               win_end;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   wcnt;
  logic [CNT_W-1:0]   spk_cnt;
  logic [CNT_W-1:0]   final_cnt;
  logic [ISI_W-1:0]   isi_cnt;
  logic [ISI_W-1:0]   isi_last;
  logic [ISI_W-1:0]   isi_closed;
  logic [ISI_W-1:0]   isi_report;
  logic               isi_seen;

  spike_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  // Window results include an edge that lands on the window's last cycle
  assign final_cnt  = CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX, spike_edge));
  assign isi_closed = ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX, 1'b1));
  assign isi_report = (spike_edge && isi_seen) ? isi_closed : isi_last;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus window start/end strobes; disabled cycles never advance
  always_comb begin
    state_next = state;
    win_start  = 1'b0;
    win_end    = 1'b0;
    case (state)
      IDLE: begin
        if (ena && (win_len != '0)) begin
          win_start  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (ena && (wcnt == win_q - WIN_ONE)) begin
          win_end = 1'b1;
          if (win_len == '0) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Window length latch, cycle counter and saturating spike counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      wcnt    <= '0;
      spk_cnt <= '0;
    end else if (win_start || win_end) begin
      win_q   <= win_len;
      wcnt    <= '0;
      spk_cnt <= '0;
    end else if ((state == RUN) && ena) begin
      wcnt    <= wcnt + WIN_ONE;
      spk_cnt <= CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX, spike_edge));
    end
  end

  // Interval tracking runs in both states; the first edge only arms it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt  <= '0;
      isi_last <= '0;
      isi_seen <= 1'b0;
    end else if (ena) begin
      if (spike_edge) begin
        if (isi_seen) begin
          isi_last <= isi_closed;
        end
        isi_cnt  <= '0;
        isi_seen <= 1'b1;
      end else begin
        isi_cnt <= ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX, 1'b1));
      end
    end
  end

  // Output register: load on window end when free or being drained,
  // otherwise drop the new result and raise the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rate_out  <= '0;
      isi_out   <= '0;
      ovf       <= 1'b0;
    end else if (win_end) begin
      if (!out_valid || out_ready) begin
        rate_out  <= final_cnt;
        isi_out   <= isi_report;
        out_valid <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
